// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a one-entry skid buffer and synchronous flush.
// Latency 1 cycle; accepts up to 2 entries under backpressure, in_ready drops only when the skid is full.
module pipe_stage_skid #(
   parameter int                CTRL_W      = 8,
   parameter int                DATA_W      = 69,
   parameter int                PC_W        = 32,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
   parameter bit                CLEAR_DATA  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [PC_W-1:0]   out_pc,
   output logic [1:0]        occupancy
);

   logic              main_v;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [PC_W-1:0]   main_pc;

   logic              skid_v;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [PC_W-1:0]   skid_pc;

   logic in_fire;
   logic out_fire;

   // in_ready depends only on the registered skid flag, so a full skid never
   // coincides with in_fire and the skid can be refilled while it drains.
   assign in_ready  = reset & ~skid_v;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_v & out_ready;

   assign out_valid = main_v;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
   assign out_ctrl  = main_v ? main_ctrl : BUBBLE_CTRL;
   assign out_data  = (CLEAR_DATA && !main_v) ? '0 : main_data;
   assign out_pc    = (CLEAR_DATA && !main_v) ? '0 : main_pc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         main_v    <= 1'b0;
         main_ctrl <= BUBBLE_CTRL;
         main_data <= '0;
         main_pc   <= '0;
         skid_v    <= 1'b0;
         skid_ctrl <= BUBBLE_CTRL;
         skid_data <= '0;
         skid_pc   <= '0;
      end else if (flush) begin
         main_v    <= 1'b0;
         skid_v    <= 1'b0;
         main_ctrl <= BUBBLE_CTRL;
         skid_ctrl <= BUBBLE_CTRL;
         if (CLEAR_DATA) begin
            main_data <= '0;
            main_pc   <= '0;
            skid_data <= '0;
            skid_pc   <= '0;
         end
      end else if (!main_v || out_fire) begin
         if (skid_v) begin
            main_v    <= 1'b1;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            main_pc   <= skid_pc;
            skid_v    <= in_fire;
            if (in_fire) begin
               skid_ctrl <= in_ctrl;
               skid_data <= in_data;
               skid_pc   <= in_pc;
            end
         end else if (in_fire) begin
            main_v    <= 1'b1;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            main_pc   <= in_pc;
         end else begin
            main_v <= 1'b0;
         end
      end else if (in_fire) begin
         skid_v    <= 1'b1;
         skid_ctrl <= in_ctrl;
         skid_data <= in_data;
         skid_pc   <= in_pc;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed checks of pipe_stage_skid against a queue model, for both CLEAR_DATA settings.
module tb_pipe_stage_skid;

   typedef struct packed {
      logic [7:0]  ctrl;
      logic [68:0] data;
      logic [31:0] pc;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [7:0]  in_ctrl;
   logic [68:0] in_data;
   logic [31:0] in_pc;

   logic        in_ready, out_valid;
   logic [7:0]  out_ctrl;
   logic [68:0] out_data;
   logic [31:0] out_pc;
   logic [1:0]  occupancy;

   logic        in_ready_c, out_valid_c;
   logic [7:0]  out_ctrl_c;
   logic [68:0] out_data_c;
   logic [31:0] out_pc_c;
   logic [1:0]  occupancy_c;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   ent_t        q[$];
   logic [68:0] held_d;
   logic [31:0] held_p;

   always #5 clk = ~clk;

   pipe_stage_skid #(.CLEAR_DATA(1'b0)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc),
      .occupancy(occupancy)
   );

   pipe_stage_skid #(.CLEAR_DATA(1'b1)) u_dut_clr (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_c),
      .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
      .out_valid(out_valid_c), .out_ready(out_ready),
      .out_ctrl(out_ctrl_c), .out_data(out_data_c), .out_pc(out_pc_c),
      .occupancy(occupancy_c)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [68:0] rand_data();
      logic [95:0] w;
      w = {$urandom, $urandom, $urandom};
      return w[68:0];
   endfunction

   task automatic compare();
      bit   v;
      ent_t h;
      v = (q.size() != 0);
      h = v ? q[0] : '0;
      check("in_ready",    in_ready,    reset && q.size() < 2);
      check("out_valid",   out_valid,   v);
      check("occupancy",   occupancy,   q.size());
      check("out_ctrl",    out_ctrl,    v ? h.ctrl : 8'h00);
      check("out_data",    out_data,    v ? h.data : held_d);
      check("out_pc",      out_pc,      v ? h.pc : held_p);
      check("clr_in_ready",  in_ready_c,  reset && q.size() < 2);
      check("clr_out_valid", out_valid_c, v);
      check("clr_occupancy", occupancy_c, q.size());
      check("clr_out_ctrl",  out_ctrl_c,  v ? h.ctrl : 8'h00);
      check("clr_out_data",  out_data_c,  v ? h.data : 69'd0);
      check("clr_out_pc",    out_pc_c,    v ? h.pc : 32'd0);
   endtask

   // Model: entries held are a FIFO of depth 2; the head register keeps the
   // last head seen when the stage empties (only visible with CLEAR_DATA=0).
   task automatic model_edge();
      bit   in_fire, out_fire;
      ent_t e;
      if (!reset) begin
         q.delete();
         held_d = '0;
         held_p = '0;
      end else begin
         in_fire  = in_valid && (q.size() < 2);
         out_fire = (q.size() != 0) && out_ready;
         if (flush) begin
            q.delete();
         end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) begin
               e.ctrl = in_ctrl;
               e.data = in_data;
               e.pc   = in_pc;
               q.push_back(e);
            end
            if (q.size() != 0) begin
               held_d = q[0].data;
               held_p = q[0].pc;
            end
         end
      end
   endtask

   task automatic cycle(input logic r, input logic f, input logic iv, input logic [7:0] c,
                        input logic [31:0] p, input logic ordy);
      @(negedge clk);
      reset     = r;
      flush     = f;
      in_valid  = iv;
      in_ctrl   = c;
      in_data   = rand_data();
      in_pc     = p;
      out_ready = ordy;
      #1;
      if (chk_en) compare();
      @(posedge clk);
      model_edge();
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0; in_pc = '0;
      held_d = '0; held_p = '0;

      // Reset held for two cycles with input offered
      cycle(0, 0, 1, 8'hFF, 32'h1111, 0);
      chk_en = 1'b1;
      cycle(0, 0, 1, 8'hFF, 32'h1111, 0);
      cycle(1, 0, 0, 8'h00, 32'h0, 0);

      // Streaming
      cycle(1, 0, 1, 8'h11, 32'h3000, 1);
      cycle(1, 0, 1, 8'h12, 32'h3004, 1);
      cycle(1, 0, 1, 8'h13, 32'h3008, 1);
      repeat (3) cycle(1, 0, 0, 8'h00, 32'h0, 1);

      // Backpressure: A, B taken, C waits until the skid drains
      cycle(1, 0, 1, 8'h21, 32'hA000, 0);
      cycle(1, 0, 1, 8'h22, 32'hB000, 0);
      cycle(1, 0, 1, 8'h23, 32'hC000, 0);
      cycle(1, 0, 1, 8'h23, 32'hC000, 0);
      cycle(1, 0, 1, 8'h23, 32'hC000, 1);
      cycle(1, 0, 1, 8'h23, 32'hC000, 1);
      repeat (4) cycle(1, 0, 0, 8'h00, 32'h0, 1);

      // Flush with two held and D offered
      cycle(1, 0, 1, 8'h31, 32'hE000, 0);
      cycle(1, 0, 1, 8'h32, 32'hF000, 0);
      cycle(1, 1, 1, 8'h33, 32'hD000, 1);
      repeat (3) cycle(1, 0, 0, 8'h00, 32'h0, 1);

      // Bubble gating
      cycle(1, 0, 1, 8'h3C, 32'h4000, 1);
      repeat (3) cycle(1, 0, 0, 8'h00, 32'h0, 1);

      // Reset mid-operation with two held
      cycle(1, 0, 1, 8'h41, 32'h5000, 0);
      cycle(1, 0, 1, 8'h42, 32'h5004, 0);
      cycle(0, 0, 0, 8'h00, 32'h0, 1);
      repeat (3) cycle(1, 0, 0, 8'h00, 32'h0, 1);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 199) != 0,
               $urandom_range(0, 39) == 0,
               $urandom_range(0, 3) != 0,
               8'($urandom),
               $urandom,
               (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (E→M style) in the five-stage core.
- Carries one stage's control bundle, datapath word and PC to the next stage.
- Adds valid/ready handshaking, a one-entry skid buffer so backpressure does not cost throughput, and a synchronous flush.
- Instantiated between any two stages. Control fields are forced to a bubble pattern whenever the stage holds nothing.

Parameters:
- CTRL_W, 8: width of the control bundle (RegWrite, MemWrite, MemtoReg, …).
- DATA_W, 69: width of the datapath bundle (ALUOut, MemData, WriteReg).
- PC_W, 32: width of the PC field.
- BUBBLE_CTRL, 0: control pattern presented when out_valid=0 and after reset/flush.
- CLEAR_DATA, 0: 1 = zero data/PC on reset/flush/bubble; 0 = data/PC hold their last value.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-low reset (reset==0 resets on the clk edge).
- flush, in, 1: synchronous kill of all held entries.
- in_valid, in, 1: upstream offers an entry.
- in_ready, out, 1: stage can accept this cycle.
- in_ctrl, in, CTRL_W: upstream control bundle.
- in_data, in, DATA_W: upstream datapath bundle.
- in_pc, in, PC_W: upstream PC.
- out_valid, out, 1: head entry present.
- out_ready, in, 1: downstream accepts the head.
- out_ctrl, out, CTRL_W: head control, or BUBBLE_CTRL when !out_valid.
- out_data, out, DATA_W: head datapath.
- out_pc, out, PC_W: head PC.
- occupancy, out, 2: number of held entries, 0..2.

Behaviour:
- Storage:
  - main register (head), with main_v.
  - skid register, with skid_v.
- Control outputs:
  - out_valid = main_v.
  - in_ready = ~skid_v, forced 0 while reset==0.
  - occupancy = main_v + skid_v.
  - All outputs are decoded directly from registers; no combinational path from in_* to out_*.
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = main_v & out_ready.
- Reset, when reset==0 at a clk edge:
  - main_v=0, skid_v=0.
  - out_ctrl=BUBBLE_CTRL.
  - out_data and out_pc are 0 regardless of CLEAR_DATA.
  - occupancy=0.
  - in_ready reads 1 from the first cycle after reset is released.
- Flush, when flush=1 with reset=1:
  - Next state: main_v=0, skid_v=0.
  - Any simultaneous in_fire is discarded.
  - A simultaneous out_fire is still considered consumed downstream.
  - Data/PC are zeroed if CLEAR_DATA=1, else held.
- Normal update, in priority order:
  1. Head empty, or out_fire: head loads skid if skid_v (skid_v clears unless in_fire refills it); otherwise head loads input if in_fire; otherwise main_v←0.
  2. Head full, no out_fire, in_fire: entry goes to skid, skid_v←1.
  3. Otherwise: hold.
- In case 1 with skid_v and in_fire simultaneous, the skid is reloaded with the input in the same cycle. This is legal only because in_ready was computed from the old skid_v, which is 0 whenever in_fire is possible. The condition therefore reduces to "skid_v=0 → input loads head".
- Latency and ordering:
  - Latency is 1 cycle from in_fire to out_valid when empty.
  - Sustained throughput is 1 entry/cycle with out_ready held high.
  - Strict FIFO order.
  - No entry is ever duplicated or dropped except by flush.
- Backpressure:
  - With out_ready low, at most 2 entries are accepted, then in_ready=0.
  - in_ready returns to 1 the cycle after the first out_fire.
- Bubble gating:
  - out_ctrl equals BUBBLE_CTRL in every cycle where out_valid=0, so downstream write enables are inherently inactive.
- Simultaneous reset and flush: reset wins.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_ctrl=8'hFF → out_valid=0, out_ctrl=8'h00, occupancy=0, out_pc=0, in_ready=0. After release, in_ready=1.
- Streaming: out_ready=1, push PCs 0x3000, 0x3004, 0x3008 on consecutive cycles → out_pc shows 0x3000/0x3004/0x3008 one cycle later each, with no gaps; occupancy never exceeds 1.
- Backpressure: out_ready=0, push A, B, C → A and B accepted, occupancy=2, in_ready=0, C held upstream. Then raise out_ready → A, B, C emerge in order; in_ready=1 the cycle after A leaves.
- Flush: with 2 entries held and in_valid=1 offering D, pulse flush for 1 cycle → next cycle occupancy=0, out_valid=0, out_ctrl=BUBBLE_CTRL, and D never appears.
- Bubble gating: idle input with out_ready=1 after one entry with ctrl=8'h3C → out_ctrl=8'h3C for exactly 1 cycle, then 8'h00. With CLEAR_DATA=1, out_data=0; with CLEAR_DATA=0, out_data holds.
- Reset mid-operation: occupancy=2, drive reset=0 with out_ready=1 → next edge everything clears and no entry is delivered afterwards.
